// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage MIPS pipeline.
// Holds the EX/MEM register, a word-addressed data memory, the branch
// decision (pcsrc) and the MEM/WB register.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned accesses are trapped and reported on a sticky misalign_err.
// When it is undefined, address bits [1:0] are ignored.
module mem_stage #(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] npc_target,
  output logic [1:0]  mwb_wb_ctl,
  output logic [31:0] mwb_read_data,
  output logic [31:0] mwb_alu_result,
  output logic [4:0]  mwb_dest,
  output logic        misalign_err
);

  typedef struct packed {
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] npc;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  dest;
  } exm_t;

  typedef struct packed {
    logic [1:0]  wb_ctl;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dest;
  } mwb_t;

  exm_t exm_d, exm_q;
  mwb_t mwb_d, mwb_q;

  logic [31:0]        dmem_q [DMEM_WORDS];
  logic [DMEM_AW-1:0] mem_idx_s;
  logic               misalign_s;
  logic               mem_we_s;
  logic [31:0]        mem_rdata_s;

  // EX/MEM next state: flush inserts a bubble and outranks stall, which holds.
  always_comb begin
    exm_d = exm_q;
    if (flush) begin
      exm_d = '0;
    end else if (stall) begin
      exm_d = exm_q;
    end else begin
      exm_d.wb_ctl     = wb_ctlout;
      exm_d.branch     = branch;
      exm_d.memread    = memread;
      exm_d.memwrite   = memwrite;
      exm_d.npc        = EX_MEM_NPC;
      exm_d.zero       = zero;
      exm_d.alu_result = alu_result;
      exm_d.rdata2     = rdata2out;
      exm_d.dest       = five_bit_muxout;
    end
  end

  // EX/MEM pipeline register; async reset clears every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_q <= '0;
    end else begin
      exm_q <= exm_d;
    end
  end

  // Word index: upper address bits are dropped so accesses wrap around memory.
  assign mem_idx_s = exm_q.alu_result[DMEM_AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  // A memory access whose byte offset is non-zero is treated as misaligned.
  always_comb begin
    if ((exm_q.memread || exm_q.memwrite) && (exm_q.alu_result[1:0] != 2'b00)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
  end

  logic misalign_err_d, misalign_err_q;

  // Sticky error: once set it remains set until reset.
  always_comb begin
    if (misalign_s) begin
      misalign_err_d = 1'b1;
    end else begin
      misalign_err_d = misalign_err_q;
    end
  end

  // Misalignment error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  assign misalign_s   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Write enable: a stall suppresses the store; a trapped store never lands.
  always_comb begin
    if (exm_q.memwrite && !stall && !misalign_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Combinational read of the old word; loads return 0 when inactive or trapped.
  always_comb begin
    if (exm_q.memread && !misalign_s) begin
      mem_rdata_s = dmem_q[mem_idx_s];
    end else begin
      mem_rdata_s = 32'h0000_0000;
    end
  end

  // Data memory storage; contents are intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      dmem_q[mem_idx_s] <= exm_q.rdata2;
    end
  end

  // MEM/WB next state: hold on stall unless a flush is also present.
  always_comb begin
    mwb_d = mwb_q;
    if (stall && !flush) begin
      mwb_d = mwb_q;
    end else begin
      mwb_d.wb_ctl     = exm_q.wb_ctl;
      mwb_d.read_data  = mem_rdata_s;
      mwb_d.alu_result = exm_q.alu_result;
      mwb_d.dest       = exm_q.dest;
    end
  end

  // MEM/WB pipeline register; async reset clears every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwb_q <= '0;
    end else begin
      mwb_q <= mwb_d;
    end
  end

  assign pcsrc          = exm_q.branch & exm_q.zero;
  assign npc_target     = exm_q.npc;
  assign mwb_wb_ctl     = mwb_q.wb_ctl;
  assign mwb_read_data  = mwb_q.read_data;
  assign mwb_alu_result = mwb_q.alu_result;
  assign mwb_dest       = mwb_q.dest;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  wb_ctlout;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic [31:0] EX_MEM_NPC;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        pcsrc;
  logic [31:0] npc_target;
  logic [1:0]  mwb_wb_ctl;
  logic [31:0] mwb_read_data;
  logic [31:0] mwb_alu_result;
  logic [4:0]  mwb_dest;
  logic        misalign_err;

  int checks;
  int failures;

  mem_stage #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
    .EX_MEM_NPC(EX_MEM_NPC), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
    .pcsrc(pcsrc), .npc_target(npc_target), .mwb_wb_ctl(mwb_wb_ctl),
    .mwb_read_data(mwb_read_data), .mwb_alu_result(mwb_alu_result),
    .mwb_dest(mwb_dest), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [1:0] wb, input logic br, input logic mr, input logic mw,
                        input logic [31:0] npc, input logic z, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] dst);
    wb_ctlout = wb; branch = br; memread = mr; memwrite = mw;
    EX_MEM_NPC = npc; zero = z; alu_result = alu; rdata2out = wd; five_bit_muxout = dst;
  endtask

  task automatic idle_ex();
    set_ex(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w4_after_mis;
  logic [31:0] mis_load_exp;
  logic [31:0] mis_flag_exp;

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    w4_after_mis = 32'hDEAD_BEEF;
    mis_load_exp = 32'h0000_0000;
    mis_flag_exp = 32'h1;
`else
    w4_after_mis = 32'h1313_1313;
    mis_load_exp = 32'h1313_1313;
    mis_flag_exp = 32'h0;
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    idle_ex();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pcsrc",  {31'd0, pcsrc}, 32'h0);
    check("rst_npc",    npc_target, 32'h0);
    check("rst_wbctl",  {30'd0, mwb_wb_ctl}, 32'h0);
    check("rst_rdata",  mwb_read_data, 32'h0);
    check("rst_alu",    mwb_alu_result, 32'h0);
    check("rst_dest",   {27'd0, mwb_dest}, 32'h0);
    check("rst_mis",    {31'd0, misalign_err}, 32'h0);
    rst_n = 1'b1;

    // store then load to 0x10
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
    tick();
    set_ex(2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 32'h0, 5'd5);
    tick();
    idle_ex();
    tick();
    check("ld_data",  mwb_read_data, 32'hDEAD_BEEF);
    check("ld_wbctl", {30'd0, mwb_wb_ctl}, 32'h3);
    check("ld_alu",   mwb_alu_result, 32'h10);
    check("ld_dest",  {27'd0, mwb_dest}, 32'd5);
    check("st_mem4",  dut.dmem_q[4], 32'hDEAD_BEEF);

    // branch taken / not taken
    set_ex(2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0);
    tick();
    check("br_take",  {31'd0, pcsrc}, 32'h1);
    check("br_npc",   npc_target, 32'h40);
    set_ex(2'b00, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    check("br_ntake", {31'd0, pcsrc}, 32'h0);
    check("br_npc2",  npc_target, 32'h80);
    idle_ex();
    tick();

    // stall holding a store
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 32'hA5A5_A5A5, 5'd1);
    tick();
    set_ex(2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 32'h1111_2222, 5'd3);
    tick();
    stall = 1'b1;
    set_ex(2'b11, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h24, 32'h0000_0099, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_mem8", dut.dmem_q[8], 32'hA5A5_A5A5);
      check("stl_dest", {27'd0, mwb_dest}, 32'd1);
    end
    stall = 1'b0;
    idle_ex();
    tick();
    check("stl_commit", dut.dmem_q[8], 32'h1111_2222);
    check("stl_dest2",  {27'd0, mwb_dest}, 32'd3);
    check("stl_wbctl",  {30'd0, mwb_wb_ctl}, 32'h2);

    // flush + stall with a new store on the EX inputs
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h30, 32'h0BAD_F00D, 5'd0);
    tick();
    idle_ex();
    tick();
    flush = 1'b1; stall = 1'b1;
    set_ex(2'b11, 1'b1, 1'b0, 1'b1, 32'h77, 1'b1, 32'h30, 32'h1234_5678, 5'd4);
    tick();
    check("fl_npc",   npc_target, 32'h0);
    check("fl_pcsrc", {31'd0, pcsrc}, 32'h0);
    flush = 1'b0; stall = 1'b0;
    idle_ex();
    tick();
    tick();
    check("fl_mem12", dut.dmem_q[12], 32'h0BAD_F00D);
    check("fl_wbctl", {30'd0, mwb_wb_ctl}, 32'h0);

    // flush does not cancel the store already in EX/MEM
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h34, 32'hCAFE_F00D, 5'd0);
    tick();
    flush = 1'b1;
    idle_ex();
    tick();
    flush = 1'b0;
    check("fl_keep", dut.dmem_q[13], 32'hCAFE_F00D);

    // address wrap
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h400, 32'h600D_D00D, 5'd0);
    tick();
    idle_ex();
    tick();
    check("wrap_mem0", dut.dmem_q[0], 32'h600D_D00D);

    // misaligned store to 0x13, then misaligned load from 0x11
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h13, 32'h1313_1313, 5'd0);
    tick();
    set_ex(2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h11, 32'h0, 5'd2);
    tick();
    check("mis_mem4", dut.dmem_q[4], w4_after_mis);
    check("mis_flag", {31'd0, misalign_err}, mis_flag_exp);
    idle_ex();
    tick();
    check("mis_load", mwb_read_data, mis_load_exp);

    // read-before-write on the same word
    set_ex(2'b11, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h10, 32'h7777_8888, 5'd7);
    tick();
    idle_ex();
    tick();
    check("rbw_data", mwb_read_data, w4_after_mis);
    check("rbw_mem4", dut.dmem_q[4], 32'h7777_8888);

    // reset mid-cycle cancels a pending store
    set_ex(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h40, 32'h0000_0001, 5'd0);
    tick();
    idle_ex();
    tick();
    set_ex(2'b11, 1'b1, 1'b0, 1'b1, 32'h88, 1'b1, 32'h40, 32'hFFFF_0000, 5'd6);
    tick();
    check("pre_rst_pcsrc", {31'd0, pcsrc}, 32'h1);
    check("pre_rst_npc",   npc_target, 32'h88);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pcsrc", {31'd0, pcsrc}, 32'h0);
    check("arst_npc",   npc_target, 32'h0);
    check("arst_mis",   {31'd0, misalign_err}, 32'h0);
    check("arst_wbctl", {30'd0, mwb_wb_ctl}, 32'h0);
    tick();
    check("arst_mem16", dut.dmem_q[16], 32'h0000_0001);
    rst_n = 1'b1;
    idle_ex();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
